// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and default widths for the pipelined register file
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with claim/clear and two lookup ports
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic [ADDR_W-1:0] look_addr1_i,
    input  logic [ADDR_W-1:0] look_addr2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied after clear so a new producer supersedes a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1_o = busy_q[look_addr1_i];
    assign busy2_o = busy_q[look_addr2_i];

endmodule

// File: rtl/pipelined_register_file.sv
// rtl/pipelined_register_file.sv - decode-stage register file with clear sequence, bypass and scoreboard
module pipelined_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              wr_ok;
    logic              sb_busy1, sb_busy2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = RF_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == RF_READY);
    assign wr_ok = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    // Zero register beats bypass, bypass beats the stored value.
    always_comb begin
        rd1_d = mem_q[rd_addr1];
        rd2_d = mem_q[rd_addr2];
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
            rd1_d = wr_data;
        end
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
            rd2_d = wr_data;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd1_d = '0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else if (ready && rd_en) begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign rd_data1 = rd1_q;
    assign rd_data2 = rd2_q;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .clr_en_i     (ready && wr_en),
        .clr_addr_i   (wr_addr),
        .set_en_i     (ready && claim_en),
        .set_addr_i   (claim_addr),
        .look_addr1_i (rd_addr1),
        .look_addr2_i (rd_addr2),
        .busy1_o      (sb_busy1),
        .busy2_o      (sb_busy2)
    );

    assign busy1 = ready && sb_busy1;
    assign busy2 = ready && sb_busy2;

endmodule
